// File: rtl/byte_data_memory_if.sv
// Request/ready bus between the MEM stage and byte_data_memory.
// The master drives the access; the slave returns load data and status pulses.
interface byte_data_memory_if;
    logic        Request;
    logic        Write;
    logic [1:0]  Size;
    logic        Unsigned;
    logic [31:0] Address;
    logic [31:0] DataIn;
    logic        Ready;
    logic [31:0] DataOut;
    logic        DataValid;
    logic        Fault;
    logic        Busy;

    modport master (
        output Request, Write, Size, Unsigned, Address, DataIn,
        input  Ready, DataOut, DataValid, Fault, Busy
    );

    modport slave (
        input  Request, Write, Size, Unsigned, Address, DataIn,
        output Ready, DataOut, DataValid, Fault, Busy
    );
endinterface

// File: rtl/byte_data_memory.sv
// Byte/halfword/word data memory with lane-merged stores, extended loads,
// misalignment faults and a post-reset fill sequence (word i = i*INIT_STRIDE).
module byte_data_memory #(
    parameter int ADDR_BITS   = 5,
    parameter int INIT_STRIDE = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    byte_data_memory_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic {INIT, IDLE} state_t;

    state_t               state_reg;
    logic [ADDR_BITS-1:0] init_cnt_reg;
    logic                 ready_reg;
    logic                 valid_reg;
    logic                 fault_reg;
    logic [31:0]          dout_reg;

    logic [31:0]          mem [DEPTH];

    logic [1:0]           offset;
    logic [ADDR_BITS-1:0] word_idx;
    logic                 unused_addr_bits;

    assign offset           = bus.Address[1:0];
    assign word_idx         = bus.Address[ADDR_BITS+1:2];
    assign unused_addr_bits = ^bus.Address[31:ADDR_BITS+2];

    logic misaligned;
    always_comb begin
        misaligned = 1'b0;
        case (bus.Size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = offset[0];
            2'b10:   misaligned = |offset;
            default: misaligned = 1'b1;
        endcase
    end

    logic accept, do_store, do_load, do_fault;
    assign accept   = bus.Request & ready_reg;
    assign do_fault = accept & misaligned;
    assign do_store = accept & ~misaligned & bus.Write;
    assign do_load  = accept & ~misaligned & ~bus.Write;

    // Store data is replicated across lanes so the lane mask alone picks placement.
    logic [3:0]  lane_mask;
    logic [31:0] store_data;
    always_comb begin
        lane_mask  = 4'b1111;
        store_data = bus.DataIn;
        case (bus.Size)
            2'b00: begin
                lane_mask  = 4'b0001 << offset;
                store_data = {4{bus.DataIn[7:0]}};
            end
            2'b01: begin
                lane_mask  = offset[1] ? 4'b1100 : 4'b0011;
                store_data = {2{bus.DataIn[15:0]}};
            end
            default: begin
                lane_mask  = 4'b1111;
                store_data = bus.DataIn;
            end
        endcase
    end

    logic [31:0]          init_data;
    logic [3:0]           wr_lanes;
    logic [31:0]          wr_data;
    logic [ADDR_BITS-1:0] wr_idx;

    assign init_data = 32'(init_cnt_reg) * 32'(INIT_STRIDE);

    always_comb begin
        wr_lanes = 4'b0000;
        wr_data  = store_data;
        wr_idx   = word_idx;
        if (state_reg == INIT) begin
            wr_lanes = {4{~Reset}};
            wr_data  = init_data;
            wr_idx   = init_cnt_reg;
        end else begin
            wr_lanes = lane_mask & {4{do_store}};
        end
    end

    // Memory is deliberately outside the reset domain: contents survive reset.
    always_ff @(posedge Clock) begin
        for (int k = 0; k < 4; k++) begin
            if (wr_lanes[k]) begin
                mem[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
            end
        end
    end

    logic [31:0] rd_word;
    logic [7:0]  rd_bytes [4];
    assign rd_word = mem[word_idx];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rd_lane
            assign rd_bytes[gi] = rd_word[8*gi +: 8];
        end
    endgenerate

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_data;
    assign sel_byte = rd_bytes[offset];
    assign sel_half = offset[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_data = rd_word;
        case (bus.Size)
            2'b00:   load_data = {{24{~bus.Unsigned & sel_byte[7]}}, sel_byte};
            2'b01:   load_data = {{16{~bus.Unsigned & sel_half[15]}}, sel_half};
            default: load_data = rd_word;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_reg    <= INIT;
            init_cnt_reg <= '0;
            ready_reg    <= 1'b0;
            valid_reg    <= 1'b0;
            fault_reg    <= 1'b0;
            dout_reg     <= 32'h0;
        end else begin
            valid_reg <= 1'b0;
            fault_reg <= 1'b0;
            case (state_reg)
                INIT: begin
                    init_cnt_reg <= init_cnt_reg + ADDR_BITS'(1);
                    if (init_cnt_reg == ADDR_BITS'(DEPTH - 1)) begin
                        state_reg <= IDLE;
                        ready_reg <= 1'b1;
                    end
                end
                IDLE: begin
                    fault_reg <= do_fault;
                    if (do_load) begin
                        valid_reg <= 1'b1;
                        dout_reg  <= load_data;
                    end
                end
            endcase
        end
    end

    assign bus.Ready     = ready_reg;
    assign bus.Busy      = ~ready_reg;
    assign bus.DataOut   = dout_reg;
    assign bus.DataValid = valid_reg;
    assign bus.Fault     = fault_reg;
endmodule

// File: tb/tb_byte_data_memory.sv
// Self-checking bench for byte_data_memory: directed steps plus random accesses
// compared against a byte-addressed reference model of the memory.
module tb_byte_data_memory;
    localparam int ADDR_BITS = 5;
    localparam int NBYTES    = 4 << ADDR_BITS;

    logic Clock = 1'b0;
    logic Reset = 1'b1;

    byte_data_memory_if bus();

    byte_data_memory #(.ADDR_BITS(ADDR_BITS), .INIT_STRIDE(4)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  model_bytes [NBYTES];
    logic [31:0] exp_dout = 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference memory as a flat byte array, filled as word i = i*4.
    task automatic model_init();
        for (int w = 0; w < NBYTES / 4; w++)
            for (int j = 0; j < 4; j++)
                model_bytes[4*w + j] = 8'((w * 4) >> (8 * j));
    endtask

    function automatic int size_bytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                               input logic [31:0] addr);
        int          n = size_bytes(sz);
        int          a = int'(addr) & (NBYTES - 1);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < n; i++)
            v = v | (32'(model_bytes[(a + i) % NBYTES]) << (8 * i));
        if (n < 4 && !uns && v[8*n-1])
            v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic access(input string tag, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr, input logic [31:0] din);
        int          n;
        int          a;
        bit          ok;
        logic [31:0] load_val;
        n        = size_bytes(sz);
        ok       = (sz != 2'd3) && ((int'(addr[1:0]) % n) == 0);
        load_val = model_load(sz, uns, addr);
        bus.Request  = 1'b1;
        bus.Write    = wr;
        bus.Size     = sz;
        bus.Unsigned = uns;
        bus.Address  = addr;
        bus.DataIn   = din;
        @(posedge Clock);
        #1;
        bus.Request = 1'b0;
        if (ok && wr) begin
            a = int'(addr) & (NBYTES - 1);
            for (int i = 0; i < n; i++)
                model_bytes[(a + i) % NBYTES] = 8'(din >> (8 * i));
        end
        if (ok && !wr) exp_dout = load_val;
        $display("txn %s wr=%0d size=%0d uns=%0d addr=%h din=%h -> dout=%h valid=%0d fault=%0d",
                 tag, wr, sz, uns, addr, din, bus.DataOut, bus.DataValid, bus.Fault);
        check({tag, "_fault"}, 32'(bus.Fault), 32'(!ok));
        check({tag, "_valid"}, 32'(bus.DataValid), 32'(ok && !wr));
        check({tag, "_dout"}, bus.DataOut, exp_dout);
        check({tag, "_ready"}, 32'(bus.Ready), 32'd1);
    endtask

    task automatic idle_cycle(input string tag);
        bus.Request = 1'b0;
        @(posedge Clock);
        #1;
        check({tag, "_valid"}, 32'(bus.DataValid), 32'd0);
        check({tag, "_fault"}, 32'(bus.Fault), 32'd0);
        check({tag, "_dout"}, bus.DataOut, exp_dout);
    endtask

    // Counts edges until Ready rises, optionally throwing requests at the DUT meanwhile.
    task automatic wait_init(input string tag, input bit poke, input int limit, output int n);
        n = 0;
        while (n < limit) begin
            bus.Request  = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.Write    = 1'($urandom_range(0, 1));
            bus.Size     = 2'($urandom_range(0, 3));
            bus.Unsigned = 1'($urandom_range(0, 1));
            bus.Address  = 32'($urandom_range(0, 255));
            bus.DataIn   = $urandom;
            @(posedge Clock);
            #1;
            n++;
            check({tag, "_valid"}, 32'(bus.DataValid), 32'd0);
            check({tag, "_fault"}, 32'(bus.Fault), 32'd0);
            check({tag, "_busy"}, 32'(bus.Busy), 32'(!bus.Ready));
            if (bus.Ready) break;
        end
        bus.Request = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(bus.Ready), 32'd0);
        check({tag, "_busy"}, 32'(bus.Busy), 32'd1);
        check({tag, "_dout"}, bus.DataOut, 32'h0);
        check({tag, "_valid"}, 32'(bus.DataValid), 32'd0);
        check({tag, "_fault"}, 32'(bus.Fault), 32'd0);
    endtask

    task automatic random_accesses(input string tag, input int count);
        logic [1:0]  sz;
        logic [31:0] addr;
        for (int t = 0; t < count; t++) begin
            sz   = 2'($urandom_range(0, 3));
            addr = 32'($urandom_range(0, 4 * NBYTES - 1));
            if ($urandom_range(0, 1) == 1) addr = addr & ~32'(size_bytes(sz) - 1);
            if ($urandom_range(0, 7) == 0)
                idle_cycle({tag, "_idle"});
            else
                access(tag, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                       addr, $urandom);
        end
    endtask

    int cycles;

    initial begin
        bus.Request  = 1'b0;
        bus.Write    = 1'b0;
        bus.Size     = 2'b10;
        bus.Unsigned = 1'b0;
        bus.Address  = 32'h0;
        bus.DataIn   = 32'h0;

        repeat (3) @(posedge Clock);
        #1;
        check_reset_outputs("rst0");
        Reset = 1'b0;
        model_init();
        exp_dout = 32'h0;
        wait_init("init0", 1'b0, 100, cycles);
        check("init0_len", 32'(cycles), 32'd32);

        access("ld7c", 1'b0, 2'b10, 1'b0, 32'h0000_007C, 32'h0);
        check("tp_ld7c", bus.DataOut, 32'h0000_007C);

        access("sb11", 1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'h0000_00AB);
        access("lw10", 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0);
        check("tp_lw10", bus.DataOut, 32'h0000_AB10);
        access("lb11", 1'b0, 2'b00, 1'b0, 32'h0000_0011, 32'h0);
        check("tp_lb11", bus.DataOut, 32'hFFFF_FFAB);
        access("lbu11", 1'b0, 2'b00, 1'b1, 32'h0000_0011, 32'h0);
        check("tp_lbu11", bus.DataOut, 32'h0000_00AB);

        access("sh22", 1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h1234_8001);
        access("lh22", 1'b0, 2'b01, 1'b0, 32'h0000_0022, 32'h0);
        check("tp_lh22", bus.DataOut, 32'hFFFF_8001);
        access("lw20", 1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0);
        check("tp_lw20", bus.DataOut, 32'h8001_0020);

        access("lw06", 1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0);
        access("lh05", 1'b0, 2'b01, 1'b0, 32'h0000_0005, 32'h0);
        access("sz3", 1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0);
        access("sw05", 1'b1, 2'b10, 1'b0, 32'h0000_0005, 32'hFFFF_FFFF);
        access("lw04", 1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0);
        check("tp_lw04", bus.DataOut, 32'h0000_0004);
        idle_cycle("idle0");

        access("sw84", 1'b1, 2'b10, 1'b0, 32'h0000_0084, 32'hDEAD_BEEF);
        access("lw04w", 1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0);
        check("tp_wrap", bus.DataOut, 32'hDEAD_BEEF);

        random_accesses("rnd0", 300);

        // Reset during init: first let init run 10 cycles, then abort it asynchronously.
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        wait_init("init1", 1'b1, 10, cycles);
        Reset = 1'b1;
        #1;
        exp_dout = 32'h0;
        check_reset_outputs("rst1");
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;
        model_init();
        wait_init("init2", 1'b1, 100, cycles);
        check("init2_len", 32'(cycles), 32'd32);

        access("lw00", 1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0);
        check("tp_lw00", bus.DataOut, 32'h0000_0000);
        access("lw84", 1'b0, 2'b10, 1'b0, 32'h0000_0084, 32'h0);
        check("tp_lw84", bus.DataOut, 32'h0000_0004);

        random_accesses("rnd1", 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
